// File: rtl/sqrt_arb_pkg.sv
// Shared types and default sizes for the sqrt-unit arbiter.
package sqrt_arb_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int DW_DEF      = 32;
    localparam int RW_DEF      = DW_DEF / 2;
    localparam int TIMEOUT_DEF = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    // A lone requester still needs a 1-bit index.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDW_DEF = id_width(NREQ_DEF);

endpackage

// File: rtl/sqrt_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, with wrap.
module sqrt_rr_pick
    import sqrt_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IDW  = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    always_comb begin
        int j;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                idx_o    = IDW'(j);
                gnt_o[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sqrt_arbiter.sv
// Round-robin sharing of one start/done sqrt unit among NREQ requesters.
// Optional WAIT watchdog with error response: define SQRT_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | pick next requester, accept its radicand
// ISSUE | one-cycle start pulse to the sqrt unit
// WAIT  | wait for done (or watchdog expiry)
// RESP  | hold result until the originating requester takes it
module sqrt_arbiter
    import sqrt_arb_pkg::*;
#(
    parameter int NREQ        = NREQ_DEF,
    parameter int DW          = DW_DEF,
    parameter int RW          = DW / 2,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [RW-1:0]     rsp_root,
    output logic              rsp_err,
    output logic              sq_start,
    output logic [DW-1:0]     sq_radicand,
    input  logic              sq_done,
    input  logic [RW-1:0]     sq_root,
    output logic              busy
);

    localparam int IDW = id_width(NREQ);

    arb_state_e       state_q;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   rr_ptr_d;
    logic             sq_start_q;
    logic [DW-1:0]    sq_radicand_q;
    logic [RW-1:0]    rsp_root_q;
    logic [NREQ-1:0]  rsp_valid_q;

    logic [NREQ-1:0]  pick_gnt;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;

`ifdef SQRT_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0]    wd_q;
    logic             rsp_err_q;
`endif

    sqrt_rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Pointer moves just past the requester that was served.
    assign rr_ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            id_q          <= '0;
            sq_start_q    <= 1'b0;
            sq_radicand_q <= '0;
            rsp_root_q    <= '0;
            rsp_valid_q   <= '0;
`ifdef SQRT_ARB_TIMEOUT_EN
            wd_q          <= '0;
            rsp_err_q     <= 1'b0;
`endif
        end else begin
            sq_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        sq_radicand_q <= req_data[int'(pick_idx)*DW +: DW];
                        id_q          <= pick_idx;
                        sq_start_q    <= 1'b1;
                        state_q       <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
`ifdef SQRT_ARB_TIMEOUT_EN
                    wd_q    <= '0;
`endif
                end
                WAIT: begin
                    if (sq_done) begin
                        rsp_root_q        <= sq_root;
                        rsp_valid_q[id_q] <= 1'b1;
                        state_q           <= RESP;
`ifdef SQRT_ARB_TIMEOUT_EN
                        rsp_err_q         <= 1'b0;
                    end else if (wd_q == TW'(TIMEOUT_CYC - 1)) begin
                        rsp_root_q        <= '0;
                        rsp_err_q         <= 1'b1;
                        rsp_valid_q[id_q] <= 1'b1;
                        state_q           <= RESP;
                    end else begin
                        wd_q <= wd_q + TW'(1);
`endif
                    end
                end
                RESP: begin
                    if (rsp_ready[id_q]) begin
                        rsp_valid_q <= '0;
                        rr_ptr_q    <= rr_ptr_d;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready   = (state_q == IDLE) ? pick_gnt : '0;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_root    = rsp_root_q;
    assign sq_start    = sq_start_q;
    assign sq_radicand = sq_radicand_q;
    assign busy        = (state_q != IDLE);
`ifdef SQRT_ARB_TIMEOUT_EN
    assign rsp_err     = rsp_err_q;
`else
    assign rsp_err     = 1'b0;
`endif

endmodule
